// File: rtl/segment_to_nibble_rx.sv
// Receive side of the seven-segment loopback: synchronizes the pin bundle, waits for
// a pattern to stay put for STABLE_CYCLES samples, then decodes it to a nibble or flags it.
module segment_to_nibble_rx #(
  parameter int unsigned STABLE_CYCLES = 250000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [6:0] i_Segments,
  output logic [3:0] o_Nibble,
  output logic       o_Valid,
  output logic       o_Blank,
  output logic       o_Error,
  output logic [7:0] o_Error_Count
);

  localparam logic [6:0]  PIN_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [19:0] STABLE_LIM = 20'(STABLE_CYCLES);

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_t;

  // Returns {legal, nibble} for a lit-segment vector in G..A bit order.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = {1'b1, 4'h0};
      7'h06:   res = {1'b1, 4'h1};
      7'h5B:   res = {1'b1, 4'h2};
      7'h4F:   res = {1'b1, 4'h3};
      7'h66:   res = {1'b1, 4'h4};
      7'h6D:   res = {1'b1, 4'h5};
      7'h7D:   res = {1'b1, 4'h6};
      7'h07:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h6F:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h7C:   res = {1'b1, 4'hB};
      7'h39:   res = {1'b1, 4'hC};
      7'h5E:   res = {1'b1, 4'hD};
      7'h79:   res = {1'b1, 4'hE};
      7'h71:   res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [6:0]  sync_p0;
  logic [6:0]  sync_p1;
  logic [6:0]  pat_p1;
  logic [6:0]  prev_p2;
  logic [6:0]  last_pat;
  logic [19:0] count_q;
  logic [19:0] count_d;
  state_t      state_q;
  state_t      state_d;
  logic        first_q;
  logic        commit;
  logic        do_commit;
  logic [4:0]  decoded;

  // Stage 0/1: two-flop synchronizer, parked at the all-off pin level in reset
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_p0 <= PIN_OFF;
      sync_p1 <= PIN_OFF;
    end else begin
      sync_p0 <= i_Segments;
      sync_p1 <= sync_p0;
    end
  end

  assign pat_p1 = ACTIVE_LOW ? ~sync_p1 : sync_p1;

  // Stage 2: stability tracking against the previous cycle's pattern
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= SETTLE;
      count_q <= 20'd0;
      prev_p2 <= 7'h00;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      prev_p2 <= pat_p1;
      if (do_commit) begin
        first_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    commit  = 1'b0;
    if (pat_p1 != prev_p2) begin
      state_d = SETTLE;
      count_d = 20'd0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (count_q == STABLE_LIM) begin
            commit  = 1'b1;
            state_d = HOLD;
          end else begin
            count_d = count_q + 20'd1;
          end
        end
        HOLD:    state_d = HOLD;
        default: state_d = SETTLE;
      endcase
    end
  end

  // Re-committing the pattern already on record is a no-op, except right after reset.
  assign do_commit = commit && (first_q || (pat_p1 != last_pat));
  assign decoded   = decode_glyph(pat_p1);

  always_ff @(posedge i_Clk) begin
    if (do_commit) begin
      last_pat <= pat_p1;
    end
  end

  // Stage 3: registered outputs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Nibble      <= 4'h0;
      o_Valid       <= 1'b0;
      o_Blank       <= 1'b0;
      o_Error       <= 1'b0;
      o_Error_Count <= 8'h00;
    end else begin
      o_Valid <= 1'b0;
      if (do_commit) begin
        if (decoded[4]) begin
          o_Nibble <= decoded[3:0];
          o_Valid  <= 1'b1;
          o_Blank  <= 1'b0;
          o_Error  <= 1'b0;
        end else if (pat_p1 == 7'h00) begin
          o_Blank <= 1'b1;
          o_Error <= 1'b0;
        end else begin
          o_Blank       <= 1'b0;
          o_Error       <= 1'b1;
          o_Error_Count <= sat_inc(o_Error_Count);
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_to_nibble_rx.sv
// Scoreboard bench for segment_to_nibble_rx: a run-length model of the raw pins predicts
// every commit; a monitor compares the DUT outputs on the cycle each commit should land.
module tb_segment_to_nibble_rx;

  localparam int         S       = 8;
  localparam logic [6:0] OFF_RAW = 7'h7F;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] o_Nibble;
  logic       o_Valid;
  logic       o_Blank;
  logic       o_Error;
  logic [7:0] o_Error_Count;

  segment_to_nibble_rx #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Segments(seg),
    .o_Nibble(o_Nibble), .o_Valid(o_Valid), .o_Blank(o_Blank),
    .o_Error(o_Error), .o_Error_Count(o_Error_Count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         due;
    logic       valid;
    logic [3:0] nib;
    logic       blank;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_count = 0;
  int   last_valid_cyc = -1;

  // reference state
  logic [6:0] cur;
  int         run;
  logic       m_first;
  logic [6:0] m_last;
  logic [3:0] m_nib;
  logic       m_blank;
  logic       m_err;
  logic [7:0] m_cnt;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (GLYPH[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_commit(input logic [6:0] raw);
    logic [6:0] p;
    int         idx;
    exp_t       e;
    p = ~raw;
    if (!m_first && p == m_last) return;
    m_first = 1'b0;
    m_last  = p;
    idx = lookup(p);
    e.valid = 1'b0;
    if (idx >= 0) begin
      m_nib = 4'(idx); m_blank = 1'b0; m_err = 1'b0; e.valid = 1'b1;
    end else if (p == 7'h00) begin
      m_blank = 1'b1; m_err = 1'b0;
    end else begin
      m_blank = 1'b0; m_err = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    e.due = cyc + 2; e.nib = m_nib; e.blank = m_blank; e.err = m_err; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  // Reference model: a commit lands when the raw pins have held one value for S+2 samples
  // (two synchronizer samples plus S qualifying ones), visible two edges later.
  // Reset preloads the off level as already seen, so an idle bus settles to blank.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        m_first = 1'b1; m_nib = 4'h0; m_blank = 1'b0; m_err = 1'b0; m_cnt = 8'h00;
        cur = OFF_RAW; run = 3;
        e = '{due: cyc, valid: 1'b0, nib: 4'h0, blank: 1'b0, err: 1'b0, cnt: 8'h00};
        q.push_back(e);
      end else begin
        if (seg == cur) run++;
        else begin
          cur = seg; run = 1;
        end
        if (run == S + 2) model_commit(cur);
      end
    end
  end

  // Monitor: pop and compare whenever an expected output event is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_Valid === 1'b1) begin
        valid_count++;
        last_valid_cyc = cyc;
      end
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missed_event: due cycle %0d not observed (now %0d)", e.due, cyc);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("outputs{valid,nib,blank,err,cnt}",
            {17'd0, o_Valid, o_Nibble, o_Blank, o_Error, o_Error_Count},
            {17'd0, e.valid, e.nib, e.blank, e.err, e.cnt});
      end else begin
        chk("idle_valid", {31'd0, o_Valid}, 32'd0);
      end
    end
  end

  task automatic drive(input logic [6:0] v, input int n);
    seg = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int         t;
    int         vc0;
    int         choice;
    logic [6:0] raw;
    logic [6:0] p;
    rst = 1'b1;
    seg = OFF_RAW;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // glyph 2 right after reset: one pulse at t+S+3
    t = cyc + 1;
    vc0 = valid_count;
    drive(7'h24, 20);
    chk("t1_pulse_count", valid_count - vc0, 1);
    chk("t1_pulse_cycle", last_valid_cyc, t + S + 3);
    chk("t1_nibble", o_Nibble, 4'h2);
    chk("t1_blank_error", {o_Blank, o_Error}, 2'b00);

    // short glitch to glyph 1, then back to 2: no new commit
    vc0 = valid_count;
    drive(7'h79, 5);
    drive(7'h24, 50);
    chk("t2_no_pulse", valid_count - vc0, 0);
    chk("t2_nibble", o_Nibble, 4'h2);

    // long hold of glyph 8, then blank
    vc0 = valid_count;
    drive(7'h00, 200);
    chk("t3_one_pulse", valid_count - vc0, 1);
    chk("t3_nibble", o_Nibble, 4'h8);
    drive(7'h7F, 20);
    chk("t3_blank", o_Blank, 1'b1);
    chk("t3_nibble_held", o_Nibble, 4'h8);

    // illegal then glyph F
    drive(7'h36, 20);
    chk("t4_error", o_Error, 1'b1);
    chk("t4_count", o_Error_Count, 8'd1);
    drive(7'h0E, 20);
    chk("t4_nibble_F", o_Nibble, 4'hF);
    chk("t4_error_clear", o_Error, 1'b0);
    chk("t4_count_held", o_Error_Count, 8'd1);

    // 300 illegal commits saturate the error counter
    for (int i = 0; i < 150; i++) begin
      drive(7'h36, 10);
      drive(7'h6D, 10);
    end
    drive(7'h6D, 5);
    chk("t5_count_sat", o_Error_Count, 8'd255);
    chk("t5_error", o_Error, 1'b1);

    // randomized segments: legal glyphs, blanks, illegal patterns, glitches
    raw = 7'h24;
    for (int i = 0; i < 300; i++) begin
      choice = $urandom_range(0, 9);
      if (choice <= 5) raw = ~GLYPH[$urandom_range(0, 15)];
      else if (choice == 6) raw = OFF_RAW;
      else if (choice == 7) begin
        p = 7'($urandom_range(1, 127));
        while (lookup(p) >= 0) p = 7'($urandom_range(1, 127));
        raw = ~p;
      end else if (choice == 8) raw = 7'h00;
      drive(raw, $urandom_range(1, 14));
    end
    drive(raw, 20);

    // reset in the middle of settling on glyph 2
    drive(7'h24, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_reset_outputs", {o_Nibble, o_Valid, o_Blank, o_Error, o_Error_Count}, 16'h0);
    rst = 1'b0;
    t = cyc + 1;
    vc0 = valid_count;
    repeat (S + 2) @(negedge clk);
    chk("t6_no_early_pulse", valid_count - vc0, 0);
    repeat (10) @(negedge clk);
    chk("t6_pulse_count", valid_count - vc0, 1);
    chk("t6_pulse_cycle", last_valid_cyc, t + S + 3);
    chk("t6_nibble", o_Nibble, 4'h2);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
